// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, ALU codes, MUL FSM states and ALU helper for ex_stage
package ex_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000,
    ALU_NOR = 4'b1100
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return op == ALU_AND ? a & b :
           op == ALU_OR  ? a | b :
           op == ALU_ADD ? a + b :
           op == ALU_SUB ? a - b :
           op == ALU_SLT ? {{(DW-1){1'b0}}, $signed(a) < $signed(b)} :
           op == ALU_NOR ? ~(a | b) : '0;
  endfunction
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: 32-step shift-add multiplier (low 32 bits), used when EX_MUL_EN is defined
module ex_mul_seq
  import ex_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] product_o
);
  logic [DW-1:0] mcand, mplier;
  logic [RW-1:0] cnt;
  assign done_o = busy_o & (&cnt);
  // latch operands on start, then one shift-add step per cycle until the 32nd
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      busy_o    <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product_o <= '0;
    end else if (start_i) begin
      busy_o    <= 1'b1;
      cnt       <= '0;
      mcand     <= a_i;
      mplier    <= b_i;
      product_o <= '0;
    end else if (busy_o) begin
      product_o <= product_o + (mplier[0] ? mcand : '0);
      mcand     <= mcand << 1;
      mplier    <= mplier >> 1;
      cnt       <= cnt + RW'(1);
      busy_o    <= ~done_o;
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU and EX/MEM latch; define EX_MUL_EN for the multi-cycle MUL path
module ex_stage
  import ex_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic          reg_write_i,
  input  logic          alu_src_i,
  input  logic [3:0]    alu_ctrl_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic [DW-1:0] imm_i,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  input  logic [RW-1:0] rd_i,
  input  logic          wb_reg_write_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          stall_o,
  output logic          valid_o,
  output logic          reg_write_o,
  output logic [DW-1:0] alu_result_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] rd_o
);
  logic [DW-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic          bubble;
  // EX/MEM result beats MEM/WB; register 0 never forwards
  always_comb begin
    fwd_a = reg_write_o && rd_o != '0 && rd_o == rs_i ? alu_result_o :
            wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rs_i ? wb_data_i : data1_i;
    fwd_b = reg_write_o && rd_o != '0 && rd_o == rt_i ? alu_result_o :
            wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rt_i ? wb_data_i : data2_i;
  end
  assign op_b = alu_src_i ? imm_i : fwd_b;
`ifdef EX_MUL_EN
  state_e        state;
  logic          is_mul, mul_start, mul_busy, mul_done;
  logic [DW-1:0] product;
  assign is_mul    = valid_i && alu_ctrl_i == ALU_MUL;
  assign mul_start = is_mul && state == S_IDLE;
  assign stall_o   = !rst_i && is_mul && state != S_DONE;
  assign bubble    = mul_start || mul_busy;
  assign alu_res   = alu_ctrl_i == ALU_MUL ? product : alu_fn(alu_ctrl_i, fwd_a, op_b);
  ex_mul_seq u_mul (
    .clk_i,
    .rst_i,
    .start_i  (mul_start),
    .a_i      (fwd_a),
    .b_i      (op_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(product)
  );
  // MUL sequencing: IDLE -> BUSY for 32 steps -> DONE for the write-back cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_IDLE;
    else state <= state == S_IDLE ? (mul_start ? S_BUSY : S_IDLE) :
                  state == S_BUSY ? (mul_done ? S_DONE : S_BUSY) : S_IDLE;
`else
  assign stall_o = 1'b0;
  assign bubble  = 1'b0;
  assign alu_res = alu_fn(alu_ctrl_i, fwd_a, op_b);
`endif
  // EX/MEM latch: bubble while a MUL is being computed, otherwise capture this instruction
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      alu_result_o <= '0;
      store_data_o <= '0;
      rd_o         <= '0;
    end else if (bubble) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
    end else begin
      valid_o      <= valid_i;
      reg_write_o  <= reg_write_i & valid_i;
      alu_result_o <= alu_res;
      store_data_o <= fwd_b;
      rd_o         <= rd_i;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table plus multi-cycle MUL, reset and flush sequences for ex_stage
module tb_ex_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        valid_i, reg_write_i, alu_src_i, wb_reg_write_i;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] data1_i, data2_i, imm_i, wb_data_i;
  logic [4:0]  rs_i, rt_i, rd_i, wb_rd_i;
  logic        stall_o, valid_o, reg_write_o;
  logic [31:0] alu_result_o, store_data_o;
  logic [4:0]  rd_o;
  int nchk = 0, nerr = 0;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .reg_write_i(reg_write_i),
    .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .wb_reg_write_i(wb_reg_write_i),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .alu_result_o(alu_result_o), .store_data_o(store_data_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] v, rw, src, op, d1, d2, imm, rs, rt, rd, wbw, wbrd, wbd;
    logic [31:0] er, ev, erw, es;
  } vec_t;
  vec_t vt [13];

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic present_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs, input logic [4:0] rd);
    valid_i = 1'b1; reg_write_i = 1'b1; alu_src_i = 1'b0; alu_ctrl_i = 4'b1000;
    data1_i = a; data2_i = b; imm_i = '0; rs_i = rs; rt_i = rs + 5'd1; rd_i = rd;
    wb_reg_write_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
  endtask

  task automatic mul_check(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] exp);
    int lat = 0, stalls = 0, bubbles = 0;
    present_mul(a, b, rs, rd);
    for (int c = 1; c <= 60; c++) begin
      if (c == 2) begin
        data1_i = '0; data2_i = '0; wb_reg_write_i = 1'b1; wb_rd_i = rs; wb_data_i = '1;
      end
      #1;
      if (stall_o) stalls++;
      @(posedge clk_i); #1;
      if (valid_o) begin lat = c; break; end
      bubbles++;
    end
    check({n, " latency"}, lat, 34);
    check({n, " stalls"}, stalls, 33);
    check({n, " bubbles"}, bubbles, 33);
    check({n, " result"}, alu_result_o, exp);
    check({n, " reg_write"}, 32'(reg_write_o), 1);
    check({n, " rd"}, 32'(rd_o), 32'(rd));
  endtask

  initial begin
    //        v rw src op  d1            d2            imm rs rt rd wbw wbrd wbd        er             ev erw es
    vt[0]  = '{1, 1, 0, 2,  5,            7,            0,  1, 2, 4, 0, 0, 0,          12,            1, 1, 7};
    vt[1]  = '{1, 1, 0, 1,  32'h10,       0,            0,  5, 6, 3, 0, 0, 0,          32'h10,        1, 1, 0};
    vt[2]  = '{1, 1, 1, 2,  32'hDEAD,     4,            1,  3, 8, 7, 1, 3, 32'h99,     32'h11,        1, 1, 4};
    vt[3]  = '{1, 1, 1, 2,  1,            0,            2,  9, 7, 0, 1, 9, 32'h100,    32'h102,       1, 1, 32'h11};
    vt[4]  = '{1, 0, 0, 6,  20,           3,            0,  0, 0, 2, 1, 0, 32'h55,     17,            1, 0, 3};
    vt[5]  = '{1, 1, 0, 7,  32'hFFFFFFFF, 1,            0, 10,11, 5, 0, 0, 0,          1,             1, 1, 1};
    vt[6]  = '{1, 1, 0, 7,  1,            32'hFFFFFFFF, 0, 12,13, 6, 0, 0, 0,          0,             1, 1, 32'hFFFFFFFF};
    vt[7]  = '{1, 1, 0, 15, 5,            6,            0, 14,15, 7, 0, 0, 0,          0,             1, 1, 6};
    vt[8]  = '{1, 1, 0, 0,  32'hF0F0,     32'hFF00,     0, 16,17, 8, 0, 0, 0,          32'hF000,      1, 1, 32'hFF00};
    vt[9]  = '{1, 1, 0, 12, 0,            32'hF,        0, 18,19, 9, 0, 0, 0,          32'hFFFFFFF0,  1, 1, 32'hF};
    vt[10] = '{1, 1, 0, 2,  32'hFFFFFFFF, 2,            0, 20,21,10, 0, 0, 0,          1,             1, 1, 2};
    vt[11] = '{0, 1, 0, 2,  1,            2,            0, 22,23,11, 0, 0, 0,          3,             0, 0, 2};
    vt[12] = '{1, 1, 0, 3,  5,            6,            0, 24,25,12, 0, 0, 0,          0,             1, 1, 6};

    present_mul(32'd6, 32'd7, 5'd1, 5'd2);
    #3;
    check("rst valid", 32'(valid_o), 0);
    check("rst reg_write", 32'(reg_write_o), 0);
    check("rst result", alu_result_o, 0);
    check("rst store", store_data_o, 0);
    check("rst rd", 32'(rd_o), 0);
    check("rst stall", 32'(stall_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      valid_i = vt[i].v[0]; reg_write_i = vt[i].rw[0]; alu_src_i = vt[i].src[0];
      alu_ctrl_i = vt[i].op[3:0]; data1_i = vt[i].d1; data2_i = vt[i].d2; imm_i = vt[i].imm;
      rs_i = vt[i].rs[4:0]; rt_i = vt[i].rt[4:0]; rd_i = vt[i].rd[4:0];
      wb_reg_write_i = vt[i].wbw[0]; wb_rd_i = vt[i].wbrd[4:0]; wb_data_i = vt[i].wbd;
      #1;
      check($sformatf("v%0d stall", i), 32'(stall_o), 0);
      @(posedge clk_i); #1;
      check($sformatf("v%0d result", i), alu_result_o, vt[i].er);
      check($sformatf("v%0d valid", i), 32'(valid_o), vt[i].ev);
      check($sformatf("v%0d reg_write", i), 32'(reg_write_o), vt[i].erw);
      check($sformatf("v%0d store", i), store_data_o, vt[i].es);
      check($sformatf("v%0d rd", i), 32'(rd_o), vt[i].rd);
    end

`ifdef EX_MUL_EN
    mul_check("mul_ff3", 32'hFFFFFFFF, 32'd3, 5'd5, 5'd9, 32'hFFFFFFFD);
    mul_check("mul_b2b", 32'd123, 32'd1000, 5'd6, 5'd10, 32'd123000);
    present_mul(32'd6, 32'd7, 5'd1, 5'd2);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("abort valid", 32'(valid_o), 0);
    check("abort reg_write", 32'(reg_write_o), 0);
    check("abort result", alu_result_o, 0);
    check("abort store", store_data_o, 0);
    check("abort stall", 32'(stall_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mul_check("mul_rst", 32'd6, 32'd7, 5'd1, 5'd2, 32'd42);
    present_mul(32'd2, 32'd3, 5'd7, 5'd11);
    repeat (33) @(posedge clk_i);
    #1;
    check("flush done stall", 32'(stall_o), 0);
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("flush valid", 32'(valid_o), 0);
    check("flush reg_write", 32'(reg_write_o), 0);
    mul_check("mul_flush", 32'd9, 32'd9, 5'd7, 5'd11, 32'd81);
`else
    present_mul(32'd6, 32'd7, 5'd1, 5'd2);
    #1;
    check("nomul stall", 32'(stall_o), 0);
    @(posedge clk_i); #1;
    check("nomul result", alu_result_o, 0);
    check("nomul valid", 32'(valid_o), 1);
    check("nomul reg_write", 32'(reg_write_o), 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
